// File: rtl/vram_banked_arb.sv
// Banked video RAM with two ports: a single-cycle video read port and a
// handshaked register read/write port, arbitrated per bank with starvation relief.
//
//  state | meaning
//  IDLE  | no register transaction in flight
//  WAIT  | register request pending, lost its bank to video
//  ACK   | access done, reg_ack_o high for this cycle
module vram_banked_arb #(
   parameter  int NUM_BANKS  = 4,
   parameter  int BANK_AW    = 14,
   parameter  int DATA_W     = 16,
   parameter  int STARVE_MAX = 7,
   localparam int BSEL_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
   localparam int AW         = BANK_AW + $clog2(NUM_BANKS),
   localparam int MW         = DATA_W / 4
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              vid_sel_i,
   input  logic [AW-1:0]     vid_addr_i,
   output logic              vid_valid_o,
   output logic [DATA_W-1:0] vid_data_out_o,
   input  logic              reg_req_i,
   input  logic              reg_wr_i,
   input  logic [MW-1:0]     reg_mask_i,
   input  logic [AW-1:0]     reg_addr_i,
   input  logic [DATA_W-1:0] reg_data_in_i,
   output logic              reg_ack_o,
   output logic [DATA_W-1:0] reg_data_out_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [3:0]        starve_q, starve_d;
   logic              vid_valid_q;
   logic [BSEL_W-1:0] vid_bank_q, reg_bank_q;
   logic              reg_rd_q;
   logic [DATA_W-1:0] vid_hold_q, reg_hold_q;

   logic [BSEL_W-1:0] vid_bank, reg_bank;
   logic              reg_active, conflict, starve_hit, reg_win, vid_win;
   logic [DATA_W-1:0] bank_rd [NUM_BANKS];

   if (NUM_BANKS > 1) begin : g_multi
      assign vid_bank = vid_addr_i[AW-1:BANK_AW];
      assign reg_bank = reg_addr_i[AW-1:BANK_AW];
   end else begin : g_single
      assign vid_bank = '0;
      assign reg_bank = '0;
   end

   // Reset blocks both ports so no bank is touched while it is asserted.
   assign reg_active = !reset_i && reg_req_i && (state_q != ST_ACK);
   assign conflict   = vid_sel_i && reg_active && (vid_bank == reg_bank);
   assign starve_hit = (starve_q == 4'(STARVE_MAX));
   assign reg_win    = reg_active && (!conflict || starve_hit);
   assign vid_win    = !reset_i && vid_sel_i && !(conflict && reg_win);

   always_comb begin
      starve_d = starve_q;
      if (reg_win)
         starve_d = 4'd0;
      else if (reg_active && !starve_hit)
         starve_d = starve_q + 4'd1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (reg_req_i) state_d = reg_win ? ST_ACK : ST_WAIT;
         ST_WAIT: begin
            if (!reg_req_i)   state_d = ST_IDLE;
            else if (reg_win) state_d = ST_ACK;
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [DATA_W-1:0]  mem [2**BANK_AW];
      logic [DATA_W-1:0]  rd_q;
      logic               reg_here, vid_here;
      logic [BANK_AW-1:0] addr;

      assign reg_here = reg_win && (reg_bank == BSEL_W'(b));
      assign vid_here = vid_win && (vid_bank == BSEL_W'(b));
      assign addr     = reg_here ? reg_addr_i[BANK_AW-1:0] : vid_addr_i[BANK_AW-1:0];

      always_ff @(posedge clk_i) begin
         if (reg_here && reg_wr_i) begin
            for (int n = 0; n < MW; n++)
               if (reg_mask_i[n]) mem[addr][4*n +: 4] <= reg_data_in_i[4*n +: 4];
         end
         if (reg_here || vid_here)
            rd_q <= mem[addr];
      end

      assign bank_rd[b] = rd_q;
   end

   // Read data is steered by the bank captured at grant time, not the live address.
   assign vid_valid_o    = vid_valid_q;
   assign vid_data_out_o = vid_valid_q ? bank_rd[vid_bank_q] : vid_hold_q;
   assign reg_ack_o      = (state_q == ST_ACK);
   assign reg_data_out_o = (reg_ack_o && reg_rd_q) ? bank_rd[reg_bank_q] : reg_hold_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         starve_q    <= 4'd0;
         vid_valid_q <= 1'b0;
         vid_bank_q  <= '0;
         reg_bank_q  <= '0;
         reg_rd_q    <= 1'b0;
         vid_hold_q  <= '0;
         reg_hold_q  <= '0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         vid_valid_q <= vid_win;
         vid_hold_q  <= vid_data_out_o;
         reg_hold_q  <= reg_data_out_o;
         if (vid_win) vid_bank_q <= vid_bank;
         if (reg_win) begin
            reg_bank_q <= reg_bank;
            reg_rd_q   <= !reg_wr_i;
         end
      end
   end

endmodule

// File: tb/tb_vram_banked_arb.sv
// Directed and light random checks of vram_banked_arb with default parameters
// (4 banks x 16K x 16 bit, STARVE_MAX = 7).
module tb_vram_banked_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic        vid_sel;
   logic [15:0] vid_addr;
   logic        vid_valid;
   logic [15:0] vid_data;
   logic        reg_req;
   logic        reg_wr;
   logic [3:0]  reg_mask;
   logic [15:0] reg_addr;
   logic [15:0] reg_wdata;
   logic        reg_ack;
   logic [15:0] reg_rdata;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   vram_banked_arb dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .vid_sel_i      (vid_sel),
      .vid_addr_i     (vid_addr),
      .vid_valid_o    (vid_valid),
      .vid_data_out_o (vid_data),
      .reg_req_i      (reg_req),
      .reg_wr_i       (reg_wr),
      .reg_mask_i     (reg_mask),
      .reg_addr_i     (reg_addr),
      .reg_data_in_i  (reg_wdata),
      .reg_ack_o      (reg_ack),
      .reg_data_out_o (reg_rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic reg_txn(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                          input logic [3:0] mask, output logic [15:0] rdata, output int lat);
      reg_wr = wr; reg_addr = addr; reg_wdata = data; reg_mask = mask; reg_req = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!reg_ack && lat < 40);
      rdata   = reg_rdata;
      reg_req = 1'b0;
      tick();
   endtask

   function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                         input logic [3:0] mask);
      logic [15:0] r;
      r = old;
      for (int n = 0; n < 4; n++)
         if (mask[n]) r[4*n +: 4] = nw[4*n +: 4];
      return r;
   endfunction

   function automatic logic [15:0] raddr(input int idx);
      return ((idx >= 4) ? 16'h4000 : 16'h0000) + 16'(idx % 4);
   endfunction

   initial begin
      logic [15:0] rd;
      int          lat, zeros;
      logic [15:0] model [8];
      bit          vid_iss, pend, last_ack, rp_wr;
      int          vidx, ridx, wait_c;
      logic [15:0] rp_data;
      logic [3:0]  rp_mask;

      reset = 1'b1; vid_sel = 1'b0; vid_addr = '0; reg_req = 1'b0; reg_wr = 1'b0;
      reg_mask = '0; reg_addr = '0; reg_wdata = '0;
      tick(); tick();
      check("rst_vid_valid", vid_valid, 0);
      check("rst_reg_ack",   reg_ack,   0);
      check("rst_vid_data",  vid_data,  0);
      check("rst_reg_data",  reg_rdata, 0);
      reset = 1'b0;
      tick();

      // Full write then read back; one-cycle grant-to-ack
      reg_txn(1'b1, 16'h4010, 16'hABCD, 4'hF, rd, lat);
      check("wr4010_lat", lat, 1);
      check("ack_one_cycle", reg_ack, 0);
      reg_txn(1'b0, 16'h4010, 16'h0000, 4'h0, rd, lat);
      check("rd4010_lat", lat, 1);
      check("rd4010_data", rd, 16'hABCD);

      // Nibble mask write; read data holds across writes
      reg_txn(1'b1, 16'h0005, 16'h1234, 4'hF, rd, lat);
      reg_txn(1'b1, 16'h0005, 16'h0000, 4'h2, rd, lat);
      check("wr_holds_rdata", rd, 16'hABCD);
      reg_txn(1'b0, 16'h0005, 16'h0000, 4'h0, rd, lat);
      check("mask2_data", rd, 16'h1204);
      reg_txn(1'b1, 16'h0005, 16'hFFFF, 4'h0, rd, lat);
      check("mask0_lat", lat, 1);
      reg_txn(1'b0, 16'h0005, 16'h0000, 4'h0, rd, lat);
      check("mask0_data", rd, 16'h1204);

      // Video reads across banks, back to back, then hold
      vid_sel = 1'b1; vid_addr = 16'h4010;
      tick();
      vid_addr = 16'h0005;
      check("vid1_valid", vid_valid, 1);
      check("vid1_data",  vid_data,  16'hABCD);
      tick();
      vid_sel = 1'b0; vid_addr = 16'h4010;
      check("vid2_valid", vid_valid, 1);
      check("vid2_data",  vid_data,  16'h1204);
      tick();
      check("vid_idle_valid", vid_valid, 0);
      check("vid_idle_hold",  vid_data,  16'h1204);

      // Different banks: both served in the same cycle
      reg_txn(1'b1, 16'h8000, 16'h5A5A, 4'hF, rd, lat);
      reg_txn(1'b1, 16'h0000, 16'h1111, 4'hF, rd, lat);
      reg_txn(1'b1, 16'h0001, 16'h2222, 4'hF, rd, lat);
      vid_sel = 1'b1; vid_addr = 16'h0000;
      tick();
      reg_wr = 1'b0; reg_addr = 16'h8000; reg_req = 1'b1;
      tick();
      check("par_ack",       reg_ack,   1);
      check("par_rdata",     reg_rdata, 16'h5A5A);
      check("par_vid_valid", vid_valid, 1);
      check("par_vid_data",  vid_data,  16'h1111);
      reg_req = 1'b0;
      tick();
      check("par_vid_valid2", vid_valid, 1);

      // Same bank: video wins until starvation relief on the 8th cycle
      reg_addr = 16'h0001; reg_req = 1'b1;
      lat = 0; zeros = 0;
      do begin
         tick();
         lat++;
         if (!vid_valid) zeros++;
      end while (!reg_ack && lat < 40);
      check("starve_lat",       lat,       8);
      check("starve_vid_lost",  vid_valid, 0);
      check("starve_rdata",     reg_rdata, 16'h2222);
      reg_req = 1'b0;
      tick();
      check("starve_vid_back",  vid_valid, 1);
      check("starve_one_miss",  zeros,     1);

      // Reset while in WAIT drops the request; still-high req restarts it
      reg_wr = 1'b1; reg_addr = 16'h0002; reg_wdata = 16'h7777; reg_mask = 4'hF; reg_req = 1'b1;
      tick(); tick(); tick();
      check("wait_no_ack", reg_ack, 0);
      reset = 1'b1;
      tick();
      check("rst_mid_ack",   reg_ack,   0);
      check("rst_mid_valid", vid_valid, 0);
      reset = 1'b0;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!reg_ack && lat < 40);
      check("post_rst_lat", lat, 8);
      reg_req = 1'b0; vid_sel = 1'b0;
      tick();
      reg_txn(1'b0, 16'h0002, 16'h0000, 4'h0, rd, lat);
      check("post_rst_data", rd, 16'h7777);
      reg_txn(1'b0, 16'h4010, 16'h0000, 4'h0, rd, lat);
      check("mem_kept", rd, 16'hABCD);

      // Random two-port traffic against a reference model
      for (int i = 0; i < 8; i++) begin
         model[i] = 16'($urandom);
         reg_txn(1'b1, raddr(i), model[i], 4'hF, rd, lat);
      end
      pend = 0; last_ack = 0; wait_c = 0; ridx = 0; rp_wr = 0; rp_data = '0; rp_mask = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         vid_iss  = 1'($urandom_range(0, 1));
         vidx     = $urandom_range(0, 7);
         vid_sel  = vid_iss;
         vid_addr = raddr(vidx);
         if (!pend && !last_ack && $urandom_range(0, 1) == 1) begin
            pend = 1; wait_c = 0;
            ridx = $urandom_range(0, 7);
            rp_wr = 1'($urandom_range(0, 1));
            rp_data = 16'($urandom);
            rp_mask = 4'($urandom_range(0, 15));
            reg_wr = rp_wr; reg_addr = raddr(ridx); reg_wdata = rp_data; reg_mask = rp_mask;
            reg_req = 1'b1;
         end
         tick();
         if (vid_iss) begin
            if (vid_valid)
               check("rnd_vid_data", vid_data, model[vidx]);
            else
               check("rnd_vid_lost", {reg_ack, pend && (ridx / 4 == vidx / 4)}, 2'b11);
         end else begin
            check("rnd_vid_idle", vid_valid, 0);
         end
         last_ack = reg_ack;
         if (reg_ack) begin
            check("rnd_ack_pend", pend, 1);
            if (pend && !rp_wr) check("rnd_rd_data", reg_rdata, model[ridx]);
            if (pend && rp_wr)  model[ridx] = merge(model[ridx], rp_data, rp_mask);
            pend = 0; reg_req = 1'b0;
         end else if (pend) begin
            wait_c++;
            if (wait_c > 40) begin
               check("rnd_timeout", reg_ack, 1);
               pend = 0; reg_req = 1'b0;
            end
         end
      end
      vid_sel = 1'b0; reg_req = 1'b0;
      tick(); tick();
      for (int i = 0; i < 8; i++) begin
         reg_txn(1'b0, raddr(i), 16'h0000, 4'h0, rd, lat);
         check("rnd_final", rd, model[i]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vram_banked_arb.md
VRAM_BANKED_ARB -- requirements
Module: vram_banked_arb

Interface
REQ-001 Parameter NUM_BANKS, default 4, number of single-port 16K-class RAM banks; power of 2, 1..8.
REQ-002 Parameter BANK_AW, default 14, word-address width of each bank.
REQ-003 Parameter DATA_W, default 16, word width; multiple of 4.
REQ-004 Parameter STARVE_MAX, default 7, consecutive denied cycles before the register port wins a bank conflict; 1..15.
REQ-005 Derived: AW = BANK_AW + clog2(NUM_BANKS); MW = DATA_W/4; bank index = addr[AW-1:BANK_AW].
REQ-006 clk  input  1  sole clock; all state on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 vid_sel  input  1  video read request, single-cycle, no handshake.
REQ-009 vid_addr  input  AW  video read word address.
REQ-010 vid_valid  output  1  video read data valid this cycle.
REQ-011 vid_data_out  output  DATA_W  video read data.
REQ-012 reg_req  input  1  register-port request, level, held until reg_ack.
REQ-013 reg_wr  input  1  1 = write, 0 = read; stable while reg_req high.
REQ-014 reg_mask  input  MW  nibble write enables, bit n -> data[4n+3:4n].
REQ-015 reg_addr  input  AW  register-port word address.
REQ-016 reg_data_in  input  DATA_W  write data.
REQ-017 reg_ack  output  1  one-cycle completion strobe.
REQ-018 reg_data_out  output  DATA_W  read data, valid with reg_ack on reads.

Function
REQ-019 Each bank SHALL perform at most one access per cycle; the two ports targeting different banks SHALL both be serviced in the same cycle.
REQ-020 Conflict (same bank, both requesting): video SHALL win unless starve counter == STARVE_MAX, then register port wins.
REQ-021 Starve counter (4 bits) SHALL increment on each cycle the register port is pending and denied, saturate at STARVE_MAX, clear on register grant.
REQ-022 Video read latency SHALL be 1: vid_sel granted in cycle N -> vid_valid=1 and vid_data_out in N+1; vid_sel lost to starvation override -> vid_valid=0 in N+1 (caller reissues).
REQ-023 vid_valid SHALL be 0 in any cycle not following a granted vid_sel; vid_data_out holds its last value.
REQ-024 Register FSM states: IDLE, WAIT, ACK.
REQ-025 IDLE: reg_req=1 and granted -> ACK; reg_req=1 and denied -> WAIT; else stay.
REQ-026 WAIT: granted -> ACK; else stay; reg_req dropping in WAIT -> IDLE, no access.
REQ-027 ACK: reg_ack=1 for exactly this cycle; reg_req ignored; next state IDLE; peak rate one transaction per 2 cycles.
REQ-028 Granted write SHALL update only nibbles whose reg_mask bit is 1; mask 0 performs no change but still acks.
REQ-029 Granted read: reg_data_out = word at reg_addr in ACK cycle; on writes reg_data_out SHALL hold its previous value.
REQ-030 Video read of a word written by the register port in the same cycle is impossible (same bank conflicts); a video read in the cycle after a write completes SHALL return the new data.
REQ-031 Output mux SHALL use the registered bank index of the granted access, not the current address.
REQ-032 Addresses are full-range; no wrap or out-of-range case exists.

Reset
REQ-033 During reset: FSM=IDLE, starve counter=0, vid_valid=0, reg_ack=0, vid_data_out=0, reg_data_out=0; no bank written.
REQ-034 Reset mid-transaction (WAIT or ACK) SHALL drop the pending request; reg_req still high after reset is a new request.
REQ-035 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-036 Write reg_addr=0x4010, data 0xABCD, mask 0xF; read back -> reg_ack 1 cycle after grant, reg_data_out=0xABCD.
REQ-037 Word 0x1234 at 0x0005, write 0x0000 mask 0x2 -> read returns 0x1204.
REQ-038 vid_sel every cycle at 0x0000, reg read at 0x8000 -> both served same cycle, no WAIT, vid_valid continuous.
REQ-039 vid_sel every cycle at 0x0000, reg read at 0x0001, STARVE_MAX=7 -> reg port in WAIT 7 cycles, granted 8th cycle, vid_valid=0 for that one cycle only.
REQ-040 Assert reset while FSM in WAIT -> reg_ack never pulses for that request; after release with reg_req high, transaction completes normally.
REQ-041 Random two-port traffic vs. reference memory model -> all reads match, no ack lost or duplicated, no video read lost except by REQ-022 override.
